// File: rtl/rosc_sample_collector_pkg.sv
// Shared ROSC definitions: mode and ErrorCode encodings plus the collector state enum.
package rosc_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_FAST = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;

  localparam logic [2:0] EC_RESET     = 3'd0;
  localparam logic [2:0] EC_DATAREADY = 3'd1;
  localparam logic [2:0] EC_FAST      = 3'd2;
  localparam logic [2:0] EC_SLOW      = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_RDY,
    ST_ACK,
    ST_WAIT_LOW,
    ST_FINISH
  } collector_state_t;

  function automatic logic mode_valid(input logic [1:0] m);
    return (m == MODE_FAST) || (m == MODE_SLOW);
  endfunction

endpackage

// File: rtl/rosc_sample_collector_if.sv
// Collector <-> ROSC handshake bundle; master is the collector, slave is the ROSC.
interface rosc_sample_collector_if;
  logic [1:0]  Mode;
  logic        Enable;
  logic [3:0]  NumClkCycles;
  logic        CPUReadComplete;
  logic [15:0] ROSCReading;
  logic [2:0]  ErrorCode;
  logic        ROSCValReady;

  modport master (
    output Mode, Enable, NumClkCycles, CPUReadComplete,
    input  ROSCReading, ErrorCode, ROSCValReady
  );

  modport slave (
    input  Mode, Enable, NumClkCycles, CPUReadComplete,
    output ROSCReading, ErrorCode, ROSCValReady
  );
endinterface

// File: rtl/rosc_sample_collector_accum.sv
// Sum/min/max/count accumulator with clear and capture strobes.
// Min/max tracking exists only with ROSC_MINMAX_EN; otherwise o_cmp is the last reading.
module rosc_sample_accum #(
  parameter int MAX_SAMPLES = 16,
  parameter int SUM_W       = 16 + $clog2(MAX_SAMPLES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clr,
  input  logic                            i_cap,
  input  logic [15:0]                     i_data,
  output logic [SUM_W-1:0]                o_sum,
  output logic [15:0]                     o_min,
  output logic [15:0]                     o_max,
  output logic [$clog2(MAX_SAMPLES):0]    o_count,
  output logic [15:0]                     o_cmp
);
  localparam int CNT_W = $clog2(MAX_SAMPLES) + 1;

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (i_cap) begin
      r_sum   <= r_sum + {{(SUM_W-16){1'b0}}, i_data};
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sum   = r_sum;
  assign o_count = r_count;

`ifdef ROSC_MINMAX_EN
  logic [15:0] r_min;
  logic [15:0] r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= 16'hFFFF;
      r_max <= '0;
    end else if (i_clr) begin
      r_min <= 16'hFFFF;
      r_max <= '0;
    end else if (i_cap) begin
      if (i_data < r_min) r_min <= i_data;
      if (i_data > r_max) r_max <= i_data;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
  assign o_cmp = r_min;
`else
  logic [15:0] r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_last <= '0;
    else if (i_clr) r_last <= '0;
    else if (i_cap) r_last <= i_data;
  end

  assign o_min = '0;
  assign o_max = '0;
  assign o_cmp = r_last;
`endif

endmodule

// File: rtl/rosc_sample_collector.sv
// Drives the ROSC through a sampling run and accumulates its readings.
// Optional min/max tracking: define ROSC_MINMAX_EN (see rosc_sample_accum).
module rosc_sample_collector
  import rosc_pkg::*;
#(
  parameter int MAX_SAMPLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SUM_W          = 16 + $clog2(MAX_SAMPLES)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Abort,
  input  logic [1:0]                    HostMode,
  input  logic [3:0]                    HostNumClkCycles,
  input  logic [$clog2(MAX_SAMPLES)-1:0] HostNumSamples,
  input  logic [15:0]                   Threshold,
  rosc_sample_collector_if.master       rosc,
  output logic                          Busy,
  output logic                          Done,
  output logic [SUM_W-1:0]              SampleSum,
  output logic [15:0]                   SampleMin,
  output logic [15:0]                   SampleMax,
  output logic [$clog2(MAX_SAMPLES):0]  SampleCount,
  output logic                          Degraded,
  output logic                          TimeoutErr,
  output logic                          ModeErr
);
  localparam int NS_W  = $clog2(MAX_SAMPLES);
  localparam int CNT_W = NS_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  collector_state_t r_state;
  logic [1:0]       r_mode_lat;
  logic [3:0]       r_ncc;
  logic [NS_W-1:0]  r_ns_lat;
  logic [15:0]      r_thr;
  logic [1:0]       r_mode_out;
  logic             r_enable;
  logic             r_ack;
  logic             r_busy;
  logic             r_done;
  logic             r_degraded;
  logic             r_to_err;
  logic             r_mode_err;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_clr;
  logic             w_cap;
  logic             w_to_hit;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_count;
  logic [15:0]      w_cmp;

  assign w_clr    = (r_state == ST_IDLE) && Start && !Abort;
  assign w_cap    = (r_state == ST_WAIT_RDY) && !Abort && rosc.ROSCValReady &&
                    (rosc.ErrorCode == EC_DATAREADY);
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_target = (r_ns_lat == '0) ? CNT_W'(MAX_SAMPLES) : {1'b0, r_ns_lat};

  rosc_sample_accum #(
    .MAX_SAMPLES (MAX_SAMPLES),
    .SUM_W       (SUM_W)
  ) u_accum (
    .clk     (Clk),
    .rst     (Reset),
    .i_clr   (w_clr),
    .i_cap   (w_cap),
    .i_data  (rosc.ROSCReading),
    .o_sum   (SampleSum),
    .o_min   (SampleMin),
    .o_max   (SampleMax),
    .o_count (w_count),
    .o_cmp   (w_cmp)
  );

  // ROSC-facing outputs are registered alongside the state so they change on the transition edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_mode_lat <= MODE_STOP;
      r_ncc      <= '0;
      r_ns_lat   <= '0;
      r_thr      <= '0;
      r_mode_out <= MODE_STOP;
      r_enable   <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_degraded <= 1'b0;
      r_to_err   <= 1'b0;
      r_mode_err <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (Abort) begin
        r_state    <= ST_IDLE;
        r_mode_out <= MODE_STOP;
        r_enable   <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Start) begin
              r_mode_lat <= HostMode;
              r_ncc      <= HostNumClkCycles;
              r_ns_lat   <= HostNumSamples;
              r_thr      <= Threshold;
              r_to_err   <= 1'b0;
              r_degraded <= 1'b0;
              if (mode_valid(HostMode)) begin
                r_mode_err <= 1'b0;
                r_state    <= ST_ARM;
                r_mode_out <= HostMode;
                r_enable   <= 1'b1;
                r_busy     <= 1'b1;
              end else begin
                r_mode_err <= 1'b1;
              end
            end
          end
          ST_ARM: begin
            r_state  <= ST_WAIT_RDY;
            r_to_cnt <= '0;
          end
          ST_WAIT_RDY: begin
            if (w_cap) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end else if (w_to_hit) begin
              r_to_err   <= 1'b1;
              r_state    <= ST_IDLE;
              r_mode_out <= MODE_STOP;
              r_enable   <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          ST_ACK: begin
            // Fast mode stops after one sample: the ROSC only repeats its stored value.
            if ((w_count == w_target) || (r_mode_lat == MODE_FAST)) begin
              r_state    <= ST_FINISH;
              r_done     <= 1'b1;
              r_degraded <= (w_cmp < r_thr);
              r_mode_out <= MODE_STOP;
              r_enable   <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_state  <= ST_WAIT_LOW;
              r_to_cnt <= '0;
            end
          end
          ST_WAIT_LOW: begin
            if (!rosc.ROSCValReady) begin
              r_state  <= ST_WAIT_RDY;
              r_to_cnt <= '0;
            end else if (w_to_hit) begin
              r_to_err   <= 1'b1;
              r_state    <= ST_IDLE;
              r_mode_out <= MODE_STOP;
              r_enable   <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          ST_FINISH: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rosc.Mode            = r_mode_out;
  assign rosc.Enable          = r_enable;
  assign rosc.NumClkCycles    = r_ncc;
  assign rosc.CPUReadComplete = r_ack;
  assign Busy                 = r_busy;
  assign Done                 = r_done;
  assign SampleCount          = w_count;
  assign Degraded             = r_degraded;
  assign TimeoutErr           = r_to_err;
  assign ModeErr              = r_mode_err;

endmodule
